apb_req_master: RTL
===================

# apb_req_master

APB master sequencer that sits directly upstream of the UART subsystem's APB slave port and drives its PADDR/PWDATA/PWRITE/PSELx/PENABLE inputs. It accepts single register-access requests over a valid/ready handshake, runs each as a standard two-phase APB transfer, honours slave wait states via PREADY, and returns read data or a timeout error on a one-cycle response strobe. It lets firmware-style sequencers and self-checking benches exercise the slave without hand-driving bus phases.

## Interface
- ADDR_WIDTH, 8, APB address width
- DATA_WIDTH, 8, APB data width
- TIMEOUT, 16, max ACCESS-phase cycles before abort; 0 disables timeout
- PCLK  input  1  bus clock; single clock domain, all state on rising edge
- PRESETn  input  1  asynchronous, active-low reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  master can accept a request
- req_write_i  input  1  1 = write, 0 = read
- req_addr_i  input  ADDR_WIDTH  target register address
- req_wdata_i  input  DATA_WIDTH  write data
- rsp_valid_o  output  1  one-cycle response strobe
- rsp_rdata_o  output  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err_o  output  1  transfer aborted by timeout
- busy_o  output  1  transfer in progress
- PADDR_o  output  ADDR_WIDTH  APB address
- PWDATA_o  output  DATA_WIDTH  APB write data
- PWRITE_o  output  1  APB direction
- PSELx_o  output  1  APB slave select
- PENABLE_o  output  1  APB enable
- PRDATA_i  input  DATA_WIDTH  APB read data
- PREADY_i  input  1  APB slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: req_ready_o=1, PSELx_o=0, PENABLE_o=0. On req_valid_i&&req_ready_o, latch write/addr/wdata, go to SETUP.
- SETUP (exactly 1 cycle): PSELx_o=1, PENABLE_o=0, PADDR/PWRITE/PWDATA driven from the latched values; go to ACCESS.
- ACCESS: PSELx_o=1, PENABLE_o=1, same addr/data/dir. Timeout counter (width $clog2(TIMEOUT+1)) clears on ACCESS entry and increments each ACCESS cycle with PREADY_i=0.
  - PREADY_i=1 at an edge: completion. rsp_valid_o=1 for the next cycle, rsp_err_o=0, rsp_rdata_o=PRDATA_i for a read or 0 for a write. Go to IDLE.
  - Counter reaches TIMEOUT with PREADY_i=0 (TIMEOUT>0): abort. rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0. Go to IDLE.
  - PREADY_i=1 on the timeout cycle: completion wins, no error.
- busy_o = (state != IDLE). req_ready_o = (state == IDLE).
- PADDR_o/PWDATA_o/PWRITE_o keep their last values in IDLE. Outside SETUP/ACCESS they are don't-care to the slave.
- rsp_rdata_o/rsp_err_o keep their values until the next response.
- Reset: asynchronous, all outputs 0 immediately, FSM to IDLE. A transfer in flight is dropped with no response. req_ready_o goes to 1 on the first edge after release.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Request accepted at edge k: PSELx_o rises after k, PENABLE_o rises after k+1.
- Zero-wait slave: PREADY_i sampled at edge k+2. PSELx_o/PENABLE_o fall and rsp_valid_o rises after k+2.
- Each wait cycle adds 1 cycle to the transfer.
- Back-to-back throughput is one transfer per 3 cycles. A new request is accepted in the IDLE cycle that coincides with rsp_valid_o.
- Timeout response rises TIMEOUT cycles after ACCESS entry.

## Structure
- Shared package apb_master_pkg: state_t enum (IDLE, SETUP, ACCESS), default width constants, and a req_t struct {write, addr, wdata}.
- Single module, no sub-modules. The timeout counter is inline.

## Test plan
- Write addr 0x04 data 0xA5, PREADY tied 1: PSEL high 2 cycles, PENABLE 1 cycle, PWRITE=1, PADDR=0x04, PWDATA=0xA5 stable both cycles; rsp_valid_o pulse at k+3 with err=0, rdata=0.
- Read addr 0x08, slave inserts 3 wait cycles, then PRDATA=0x3C with PREADY: ACCESS lasts 4 cycles; rsp_rdata_o=0x3C, rsp_err_o=0; busy_o high for 5 cycles.
- Read with PREADY stuck 0, TIMEOUT=16: abort after 16 ACCESS cycles; rsp_err_o=1, rsp_rdata_o=0; PSEL/PENABLE drop together with the strobe.
- PREADY rises exactly on the 16th ACCESS cycle: completion, rsp_err_o=0, data captured.
- req_valid_i held high with 3 queued requests (W 0x01, R 0x01, W 0x02), zero-wait: accepts 3 cycles apart, no gap cycles, responses in order.
- PRESETn pulsed low mid-ACCESS: PSEL/PENABLE/busy_o/rsp_valid_o go 0 asynchronously; no response issued; req_ready_o=1 one edge after release; next request completes normally.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and defaults for the APB request master.
package apb_master_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } req_t;

    // A zero TIMEOUT still needs a legal one-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_req_master_if.sv
// Request/response handshake plus APB bus signals of the request master.
interface apb_req_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  busy_o;
    logic [ADDR_WIDTH-1:0] PADDR_o;
    logic [DATA_WIDTH-1:0] PWDATA_o;
    logic                  PWRITE_o;
    logic                  PSELx_o;
    logic                  PENABLE_o;
    logic [DATA_WIDTH-1:0] PRDATA_i;
    logic                  PREADY_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, PRDATA_i, PREADY_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
               PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, PRDATA_i, PREADY_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o,
               PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o
    );
endinterface

// File: rtl/apb_req_master.sv
// Runs single register requests as two-phase APB transfers with wait-state and timeout handling.
// state  | meaning
// IDLE   | waiting for a request, ready asserted
// SETUP  | PSEL high, PENABLE low, one cycle
// ACCESS | PSEL and PENABLE high until PREADY or timeout
module apb_req_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_req_master_if.master bus
);
    localparam int CNT_W = cnt_width(TIMEOUT);

    state_t                state_q, state_d;
    logic                  accept, complete, abort, timeout_hit;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ready_q, sel_q, penable_q, pwrite_q;
    logic                  rsp_valid_q, rsp_err_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q, rsp_rdata_q;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && ready_q) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready slave on the last allowed cycle beats the timeout.
                if (bus.PREADY_i) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are flopped from the next state so nothing is combinational from inputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ready_q     <= 1'b0;
            sel_q       <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
        end else begin
            ready_q     <= (state_d == IDLE);
            sel_q       <= (state_d != IDLE);
            penable_q   <= (state_d == ACCESS);
            rsp_valid_q <= complete || abort;
            if (accept) begin
                pwrite_q <= bus.req_write_i;
                paddr_q  <= bus.req_addr_i;
                pwdata_q <= bus.req_wdata_i;
            end
            if (complete) begin
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA_i;
            end else if (abort) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
            if (state_q == SETUP)
                cnt_q <= '0;
            else if (state_q == ACCESS && !bus.PREADY_i)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.busy_o      = sel_q;
    assign bus.PSELx_o     = sel_q;
    assign bus.PENABLE_o   = penable_q;
    assign bus.PWRITE_o    = pwrite_q;
    assign bus.PADDR_o     = paddr_q;
    assign bus.PWDATA_o    = pwdata_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;

endmodule
